mem_wb_reg: RTL
===============

// Module: mem_wb_reg
// PURPOSE
//  MEM/WB pipeline register of the CPU core. Captures the MEM-stage results and write-back controls each cycle.
//  Formats the raw DRAM read word into the load result (byte/half select and sign/zero extend).
//  Presents registered operands to the write-back select mux and the register-file write port.
//  Supports pipeline stall (hold) and flush (bubble insertion).
// PARAMETERS
//  DW        32  data width of all datapath operands
//  RW        5   register index width (wR)
//  CNT_W     32  retired-instruction counter width (only with MEM_WB_RETIRE_CNT_EN)
// PORTS
//  cpu_clk        in   1      core clock, all state on rising edge
//  cpu_rst_n      in   1      asynchronous active-low reset
//  stall          in   1      hold all stage registers this cycle
//  flush          in   1      replace captured entry with a bubble
//  mem_valid      in   1      MEM stage holds a real instruction
//  mem_rf_we      in   1      instruction writes the register file
//  mem_rf_wesl    in   2      write-back source select (`WB_ALU/`WB_DRAM/`WB_EXT/`WB_PC4)
//  mem_wR         in   RW     destination register index
//  mem_aluC       in   DW     ALU result; bits [1:0] are the load byte offset
//  mem_dram_raw   in   DW     raw aligned 32-bit word from DRAM
//  mem_ld_type    in   3      RV funct3 of load: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu
//  mem_ext        in   DW     immediate-extender result
//  mem_pc4        in   DW     PC+4 of the instruction
//  wb_valid       out  1      WB stage holds a real instruction
//  wb_rf_we       out  1      register-file write enable (= registered mem_rf_we & wb_valid)
//  wb_rf_wesl     out  2      registered write-back select
//  wb_wR          out  RW     registered destination index
//  wb_aluC        out  DW     registered ALU result
//  wb_dram_rdo    out  DW     registered formatted load data
//  wb_ext         out  DW     registered extender result
//  wb_pc4         out  DW     registered PC+4
//  wb_retire_cnt  out  CNT_W  retired-instruction count (only with MEM_WB_RETIRE_CNT_EN)
// BEHAVIOUR
//  - Reset (cpu_rst_n=0, async): wb_valid=0, wb_rf_we=0, wb_rf_wesl=`WB_ALU, wb_wR=0, all DW outputs=0, wb_retire_cnt=0.
//  - Latency: one cycle; MEM inputs sampled at edge N appear on wb_* after edge N. No combinational input->output path.
//  - Priority per edge: flush > stall > capture.
//    flush=1: wb_valid<=0, wb_rf_we<=0; data registers may keep old values (don't care); stall ignored.
//    stall=1,flush=0: every wb_* register holds, including wb_valid/wb_rf_we.
//    else: capture all mem_* fields; wb_valid<=mem_valid; wb_rf_we<=mem_rf_we & mem_valid.
//  - Bubble: mem_valid=0 captured -> wb_rf_we=0 regardless of mem_rf_we.
//  - wb_rf_we is never 1 for wb_wR=0? No: x0 protection is the register file's job; index passes unchanged.
//  - Load formatting (combinational before capture), off=mem_aluC[1:0], raw=mem_dram_raw:
//    lb/lbu: byte raw[8*off+7:8*off], sign-/zero-extended to DW.
//    lh/lhu: half raw[16*off[1]+15:16*off[1]], off[0] ignored, sign-/zero-extended.
//    lw and any other ld_type (011,110,111): raw unchanged, off ignored.
//    Formatting runs for every instruction; result only consumed when wb_rf_wesl=`WB_DRAM.
//  - Reset asserted mid-stall or mid-flush: reset wins immediately; pipeline resumes from bubble state.
// CONFIGURATION
//  MEM_WB_RETIRE_CNT_EN defined: CNT_W-bit counter wb_retire_cnt increments by 1 on each edge where
//    the WB entry is leaving (wb_valid=1 and stall=0, flush irrelevant), wraps to 0 after all-ones; held during stall.
//  Undefined: port wb_retire_cnt and counter logic absent; CNT_W unused.
// TESTING
//  1 Reset: cpu_rst_n=0 mid-cycle -> all wb_* zero / `WB_ALU immediately, without a clock edge.
//  2 Capture: mem_valid=1,mem_rf_we=1,wR=5,aluC=0x1000 -> next cycle wb_rf_we=1,wb_wR=5,wb_aluC=0x1000.
//  3 Loads raw=0x80FF7F01: lb off=1 -> 0x0000007F; lb off=2 -> 0xFFFFFFFF; lbu off=3 -> 0x00000080;
//    lh off=2 -> 0xFFFF80FF; lhu off=3 -> 0x000080FF; lw off=2 -> 0x80FF7F01.
//  4 Stall 3 cycles with changing mem_* -> wb_* frozen all 3 cycles; release -> next value captured.
//  5 flush=1 with stall=1, mem_valid=1 -> wb_valid=0, wb_rf_we=0 next cycle; mem_valid=0,mem_rf_we=1 -> wb_rf_we=0.
//  6 MEM_WB_RETIRE_CNT_EN: preload count near all-ones (CNT_W=4), 3 valid unstalled retires -> 15 then wraps to 0,1.

Source files
------------

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: formats DRAM load data and registers write-back operands with stall/flush.
// Optional retired-instruction counter enabled by defining MEM_WB_RETIRE_CNT_EN.

`ifndef WB_ALU
`define WB_ALU  2'b00
`endif
`ifndef WB_DRAM
`define WB_DRAM 2'b01
`endif
`ifndef WB_EXT
`define WB_EXT  2'b10
`endif
`ifndef WB_PC4
`define WB_PC4  2'b11
`endif

module mem_wb_reg #(
    parameter int DW    = 32,
    parameter int RW    = 5,
    parameter int CNT_W = 32
) (
    input  logic          cpu_clk,
    input  logic          cpu_rst_n,
    input  logic          stall,
    input  logic          flush,
    input  logic          mem_valid,
    input  logic          mem_rf_we,
    input  logic [1:0]    mem_rf_wesl,
    input  logic [RW-1:0] mem_wR,
    input  logic [DW-1:0] mem_aluC,
    input  logic [DW-1:0] mem_dram_raw,
    input  logic [2:0]    mem_ld_type,
    input  logic [DW-1:0] mem_ext,
    input  logic [DW-1:0] mem_pc4,
    output logic          wb_valid,
    output logic          wb_rf_we,
    output logic [1:0]    wb_rf_wesl,
    output logic [RW-1:0] wb_wR,
    output logic [DW-1:0] wb_aluC,
    output logic [DW-1:0] wb_dram_rdo,
    output logic [DW-1:0] wb_ext,
    output logic [DW-1:0] wb_pc4
`ifdef MEM_WB_RETIRE_CNT_EN
    ,
    output logic [CNT_W-1:0] wb_retire_cnt
`endif
);

    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;

    if (CNT_W < 1) begin : g_cnt_w_check
        $error("mem_wb_reg: CNT_W must be at least 1");
    end

    // Byte/half lane select plus sign/zero extension; unknown load types pass the word through.
    function automatic logic [DW-1:0] format_load(
        input logic [2:0]    ld_type,
        input logic [1:0]    off,
        input logic [DW-1:0] raw
    );
        logic signed [7:0]  byte_s;
        logic signed [15:0] half_s;
        logic [DW-1:0]      res;
        byte_s = raw[{off, 3'b000} +: 8];
        half_s = raw[{off[1], 4'b0000} +: 16];
        case (ld_type)
            LD_LB:   res = DW'(byte_s);
            LD_LBU:  res = DW'($unsigned(byte_s));
            LD_LH:   res = DW'(half_s);
            LD_LHU:  res = DW'($unsigned(half_s));
            default: res = raw;
        endcase
        return res;
    endfunction

    logic [DW-1:0] ld_data_p0;
    logic          capture_p0;

    assign ld_data_p0 = format_load(mem_ld_type, mem_aluC[1:0], mem_dram_raw);
    assign capture_p0 = !stall && !flush;

    // ---- MEM -> WB boundary ----
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            wb_valid <= 1'b0;
            wb_rf_we <= 1'b0;
        end else if (flush) begin
            wb_valid <= 1'b0;
            wb_rf_we <= 1'b0;
        end else if (!stall) begin
            wb_valid <= mem_valid;
            wb_rf_we <= mem_rf_we & mem_valid;
        end
    end

    // A flushed entry keeps stale data; wb_valid/wb_rf_we already mark it dead.
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            wb_rf_wesl  <= `WB_ALU;
            wb_wR       <= '0;
            wb_aluC     <= '0;
            wb_dram_rdo <= '0;
            wb_ext      <= '0;
            wb_pc4      <= '0;
        end else if (capture_p0) begin
            wb_rf_wesl  <= mem_rf_wesl;
            wb_wR       <= mem_wR;
            wb_aluC     <= mem_aluC;
            wb_dram_rdo <= ld_data_p0;
            wb_ext      <= mem_ext;
            wb_pc4      <= mem_pc4;
        end
    end

`ifdef MEM_WB_RETIRE_CNT_EN
    // An entry retires when it leaves WB; a flush only kills the incoming entry.
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            wb_retire_cnt <= '0;
        end else if (wb_valid && !stall) begin
            wb_retire_cnt <= wb_retire_cnt + CNT_W'(1);
        end
    end
`endif

endmodule
